qmult_seq: RTL and testbench

QMULT_SEQ -- requirements
Module: qmult_seq

---
 rtl/qmult_pkg.sv | 19 +
 rtl/qmult_round_sat.sv | 43 ++++
 rtl/qmult_seq.sv | 96 +++++++++
 tb/tb_qmult_seq.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/qmult_pkg.sv
// Shared types for the sequential sign-magnitude Q-format multiplier:
// FSM state encoding and the iteration-counter width derived from N.
package qmult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter must index multiplier magnitude bits 0..n-2.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n - 1);
    endfunction

    localparam int DEFAULT_N     = 32;
    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_N);

endpackage

// File: rtl/qmult_round_sat.sv
// Combinational result stage: optional rounding (QMULT_SEQ_ROUND_EN),
// overflow detection, saturation and negative-zero suppression.
module qmult_round_sat
    import qmult_pkg::*;
#(
    parameter int Q   = 15,
    parameter int N   = 32,
    parameter int SAT = 1
) (
    input  logic [2*N-3:0] acc,
    input  logic           sign,
    output logic [N-1:0]   result,
    output logic           ovr
);

    logic [N-2:0] mag_trunc;
    logic         hi_set;
    logic [N-1:0] mag_sum;
    logic [N-2:0] mag;
    logic         unused_low;

    assign mag_trunc  = acc[N-2+Q:Q];
    assign hi_set     = |acc[2*N-3:N-1+Q];
    assign unused_low = ^acc[Q-1:0];

`ifdef QMULT_SEQ_ROUND_EN
    // Adding the first discarded bit rounds ties away from zero on the magnitude.
    assign mag_sum = {1'b0, mag_trunc} + {{(N-1){1'b0}}, acc[Q-1]};
`else
    assign mag_sum = {1'b0, mag_trunc};
`endif

    assign ovr = hi_set | mag_sum[N-1];

    always_comb begin
        mag = mag_sum[N-2:0];
        if (SAT != 0 && ovr) begin
            mag = '1;
        end
        result = {sign & (|mag), mag};
    end

endmodule

// File: rtl/qmult_seq.sv
// Sequential shift-add sign-magnitude Q-format multiplier (IDLE->BUSY->DONE).
// Define QMULT_SEQ_ROUND_EN for round-to-nearest instead of truncation.
module qmult_seq
    import qmult_pkg::*;
#(
    parameter int Q   = 15,
    parameter int N   = 32,
    parameter int SAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [N-1:0] i_multiplicand,
    input  logic [N-1:0] i_multiplier,
    output logic         o_busy,
    output logic         o_done,
    output logic [N-1:0] o_result,
    output logic         o_ovr,
    output state_t       o_state
);

    localparam int CW = cnt_width(N);
    localparam int AW = 2*N - 2;

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic [AW-1:0] acc, acc_next, mcand_sh;
    logic [N-2:0]  mplr;
    logic          sign;
    logic          last_step;
    logic [N-1:0]  rs_result;
    logic          rs_ovr;

    assign last_step = (cnt == CW'(N - 2));
    assign acc_next  = acc + (mplr[0] ? mcand_sh : '0);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (i_start)   state_next = ST_BUSY;
            ST_BUSY: if (last_step) state_next = ST_DONE;
            ST_DONE:                state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    assign o_busy  = (state == ST_BUSY);
    assign o_done  = (state == ST_DONE);
    assign o_state = state;

    // The final step's sum is resolved combinationally so the result lands on the edge entering DONE.
    qmult_round_sat #(.Q(Q), .N(N), .SAT(SAT)) u_round_sat (
        .acc    (acc_next),
        .sign   (sign),
        .result (rs_result),
        .ovr    (rs_ovr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            acc      <= '0;
            mcand_sh <= '0;
            mplr     <= '0;
            sign     <= 1'b0;
            o_result <= '0;
            o_ovr    <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        mcand_sh <= {{(N-1){1'b0}}, i_multiplicand[N-2:0]};
                        mplr     <= i_multiplier[N-2:0];
                        sign     <= i_multiplicand[N-1] ^ i_multiplier[N-1];
                        acc      <= '0;
                        cnt      <= '0;
                    end
                end
                ST_BUSY: begin
                    acc      <= acc_next;
                    mcand_sh <= mcand_sh << 1;
                    mplr     <= mplr >> 1;
                    cnt      <= cnt + CW'(1);
                    if (last_step) begin
                        o_result <= rs_result;
                        o_ovr    <= rs_ovr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_qmult_seq.sv
// Self-checking bench for qmult_seq: SAT=1 and SAT=0 instances, spec-level
// arithmetic model compared every cycle, plus hand-computed directed vectors.
module tb_qmult_seq;
    import qmult_pkg::*;

    localparam int Q = 15;
    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_start = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;

    logic         busy1, done1, ovr1, busy0, done0, ovr0;
    logic [N-1:0] res1, res0;
    state_t       st1, st0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    qmult_seq #(.Q(Q), .N(N), .SAT(1)) dut1 (
        .clk(clk), .rst(rst), .i_start(i_start),
        .i_multiplicand(a), .i_multiplier(b),
        .o_busy(busy1), .o_done(done1), .o_result(res1), .o_ovr(ovr1),
        .o_state(st1)
    );

    qmult_seq #(.Q(Q), .N(N), .SAT(0)) dut0 (
        .clk(clk), .rst(rst), .i_start(i_start),
        .i_multiplicand(a), .i_multiplier(b),
        .o_busy(busy0), .o_done(done0), .o_result(res0), .o_ovr(ovr0),
        .o_state(st0)
    );

    // Returns {ovr, result} from plain integer arithmetic on the magnitudes.
    function automatic logic [N:0] model_mult(input logic [N-1:0] x, input logic [N-1:0] y,
                                              input bit sat);
        logic [63:0]  p, q;
        logic         ov;
        logic [N-2:0] mag;
        logic         sg;
        p = 64'(x[N-2:0]) * 64'(y[N-2:0]);
        q = p >> Q;
`ifdef QMULT_SEQ_ROUND_EN
        q = q + ((p >> (Q - 1)) & 64'd1);
`endif
        ov  = (q >= (64'd1 << (N - 1)));
        mag = (ov && sat) ? '1 : q[N-2:0];
        sg  = (x[N-1] ^ y[N-1]) && (mag != '0);
        return {ov, sg, mag};
    endfunction

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural timing model: N-1 busy cycles, one done cycle, results held.
    int           m_left = 0;
    bit           m_done = 1'b0;
    logic [N:0]   m_out1 = '0, m_out0 = '0, pend1 = '0, pend0 = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_left = 0;
            m_done = 1'b0;
            m_out1 = '0;
            m_out0 = '0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_done = 1'b1;
                m_out1 = pend1;
                m_out0 = pend0;
            end
        end else if (i_start) begin
            m_left = N - 1;
            pend1  = model_mult(a, b, 1'b1);
            pend0  = model_mult(a, b, 1'b0);
        end
    end

    always @(negedge clk) begin
        check("busy_sat1", N'(busy1), N'(m_left > 0));
        check("done_sat1", N'(done1), N'(m_done));
        check("result_sat1", res1, m_out1[N-1:0]);
        check("ovr_sat1", N'(ovr1), N'(m_out1[N]));
        check("busy_sat0", N'(busy0), N'(m_left > 0));
        check("done_sat0", N'(done0), N'(m_done));
        check("result_sat0", res0, m_out0[N-1:0]);
        check("ovr_sat0", N'(ovr0), N'(m_out0[N]));
    end

    task automatic start_op(input logic [N-1:0] x, input logic [N-1:0] y);
        @(negedge clk);
        a = x;
        b = y;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    // Edges counted with the start-sampling edge as edge 1.
    task automatic wait_done(output int edges, output bit ok);
        ok = 1'b0;
        edges = 1;
        for (int i = 0; i < 100; i++) begin
            if (done1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            edges++;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL done_timeout actual=none required=o_done within 100 cycles");
        end
    endtask

    task automatic do_vec(input string name, input logic [N-1:0] x, input logic [N-1:0] y,
                          input logic [N-1:0] e1, input logic o1,
                          input logic [N-1:0] e0, input logic o0);
        int edges;
        bit ok;
        logic [N:0] mm;
        mm = model_mult(x, y, 1'b1);
        check({name, "_model_sat1"}, mm[N-1:0], e1);
        mm = model_mult(x, y, 1'b0);
        check({name, "_model_sat0"}, mm[N-1:0], e0);
        start_op(x, y);
        wait_done(edges, ok);
        if (ok) begin
            check({name, "_latency"}, N'(edges), N'(N));
            check({name, "_res_sat1"}, res1, e1);
            check({name, "_ovr_sat1"}, N'(ovr1), N'(o1));
            check({name, "_res_sat0"}, res0, e0);
            check({name, "_ovr_sat0"}, N'(ovr0), N'(o0));
        end
    endtask

    logic [N-1:0] exp_small, exp_tie;
    int           busy_cnt, done_cnt;
    logic [N-1:0] got;

    initial begin
`ifdef QMULT_SEQ_ROUND_EN
        exp_small = 32'h0000_0001;
        exp_tie   = 32'h0000_0002;
`else
        exp_small = 32'h0000_0000;
        exp_tie   = 32'h0000_0001;
`endif
        #12;
        check("reset_busy", N'(busy1), '0);
        check("reset_done", N'(done1), '0);
        check("reset_result", res1, '0);
        check("reset_ovr", N'(ovr1), '0);
        @(negedge clk);
        #2 rst = 1'b1;

        do_vec("mul_1p5_x2", 32'h0000_C000, 32'h0001_0000, 32'h0001_8000, 1'b0, 32'h0001_8000, 1'b0);
        do_vec("mul_neg1_x2", 32'h8000_8000, 32'h0001_0000, 32'h8001_0000, 1'b0, 32'h8001_0000, 1'b0);
        do_vec("ovf_pos", 32'h7FFF_FFFF, 32'h0001_0000, 32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFE, 1'b1);
        do_vec("ovf_neg", 32'hFFFF_FFFF, 32'h0001_0000, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 1'b1);
        do_vec("small_round", 32'h0000_0001, 32'h0000_4000, exp_small, 1'b0, exp_small, 1'b0);
        do_vec("tie_round", 32'h0000_0003, 32'h0000_4000, exp_tie, 1'b0, exp_tie, 1'b0);
        do_vec("no_neg_zero", 32'h8000_0001, 32'h0000_0001, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0);
        do_vec("neg_x_neg", 32'h8001_8000, 32'h8000_4000, 32'h0000_C000, 1'b0, 32'h0000_C000, 1'b0);

        // Abort mid-operation with an asynchronous reset pulse.
        start_op(32'h0000_C000, 32'h0001_0000);
        repeat (9) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_busy", N'(busy1), '0);
        check("abort_done", N'(done1), '0);
        check("abort_result", res1, '0);
        check("abort_ovr", N'(ovr1), '0);
        check("abort_result_sat0", res0, '0);
        @(negedge clk);
        #2 rst = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done1) done_cnt++;
        end
        check("abort_no_done", N'(done_cnt), '0);
        do_vec("restart", 32'h0000_C000, 32'h0001_0000, 32'h0001_8000, 1'b0, 32'h0001_8000, 1'b0);

        // Operand changes and start pulses while BUSY/DONE must be ignored.
        start_op(32'h0001_8000, 32'h8000_4000);
        busy_cnt = 0;
        done_cnt = 0;
        got = '0;
        for (int i = 0; i < 60; i++) begin
            if (busy1) busy_cnt++;
            if (done1) begin
                done_cnt++;
                got = res1;
            end
            if (i == 3) begin
                a = 32'h7FFF_FFFF;
                b = 32'h7FFF_FFFF;
            end
            if (i == 5 || i == 20 || i == 31) i_start = 1'b1;
            else i_start = 1'b0;
            @(negedge clk);
        end
        i_start = 1'b0;
        check("ignore_busy_cycles", N'(busy_cnt), N'(N - 1));
        check("ignore_done_count", N'(done_cnt), N'(1));
        check("ignore_result", got, 32'h8000_C000);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
